// File: rtl/core_hazard_pkg.sv
// Shared encodings and helpers for the core hazard/stall logic.
package core_hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_IWAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int LU_DEPTH_EX  = 2;
  localparam int LU_DEPTH_MEM = 1;
  localparam int LU_W         = 2;

  function automatic logic src_hit(
    input logic       use_src,
    input logic [4:0] src,
    input logic [4:0] dst
  );
    return use_src && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_watchdog.sv
// Cache-wait watchdog and saturating stall-cycle counter.
module hazard_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             waiting_i,
  input  logic             hold_pc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             timeout_o
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             tmo_q, tmo_d;
  logic             expire;

  always_comb begin
    expire  = waiting_i && (wait_q == WC_LAST);
    wait_d  = '0;
    if (waiting_i) begin
      wait_d = expire ? wait_q : wait_q + 1'b1;
    end
    tmo_d   = tmo_q | expire;
    stall_d = stall_q;
    if (hold_pc_i && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q  <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign timeout_o      = tmo_q | expire;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, cache-wait freeze and redirect flush control
// for the 5-stage core pipeline registers.
module hazard_stall_unit
  import core_hazard_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rs1_ID,
  input  logic [4:0]       i_rs2_ID,
  input  logic             i_use_rs1_ID,
  input  logic             i_use_rs2_ID,
  input  logic [4:0]       i_write_reg_EX,
  input  logic             i_regwrite_EX,
  input  logic             i_memtoreg_EX,
  input  logic [4:0]       i_write_reg_MEM,
  input  logic             i_regwrite_MEM,
  input  logic             i_memtoreg_MEM,
  input  logic             i_redirect_EX,
  input  logic             i_imem_req,
  input  logic             i_imem_ready,
  input  logic             i_dmem_req_MEM,
  input  logic             i_dmem_ready,
  output logic             o_hold_PC,
  output logic             o_hold_IFID,
  output logic             o_flush_IFID,
  output logic             o_hold_IDEX,
  output logic             o_flush_IDEX,
  output logic             o_hold_EXMEM,
  output logic             o_hold_MEMWB,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic             o_timeout
);

  hz_state_e       state_q, state_d;
  logic [LU_W-1:0] lu_q, lu_d;
  logic            pend_q, pend_d;

  logic in_dw, in_iw;
  logic hit_ex, hit_mem, lu_act;
  logic dstall, istall, redir;
  logic hold_pc, hold_ifid, flush_ifid;
  logic hold_idex, flush_idex;
  logic hold_exmem, hold_memwb;
  logic hold_pc_g, waiting;

  always_comb begin
    in_dw   = (state_q == S_DWAIT);
    in_iw   = (state_q == S_IWAIT);
    hit_ex  = i_regwrite_EX && i_memtoreg_EX &&
              (src_hit(i_use_rs1_ID, i_rs1_ID, i_write_reg_EX) ||
               src_hit(i_use_rs2_ID, i_rs2_ID, i_write_reg_EX));
    hit_mem = i_regwrite_MEM && i_memtoreg_MEM &&
              (src_hit(i_use_rs1_ID, i_rs1_ID, i_write_reg_MEM) ||
               src_hit(i_use_rs2_ID, i_rs2_ID, i_write_reg_MEM));
    lu_act  = hit_ex || hit_mem || (lu_q != '0);
    dstall  = !i_dmem_ready && (i_dmem_req_MEM || in_dw);
    istall  = !i_imem_ready && (i_imem_req || in_iw);
    // Outside a D-stall, being in S_DWAIT means this is the release cycle.
    redir   = i_redirect_EX || (in_dw && pend_q);

    state_d    = state_q;
    lu_d       = lu_q;
    pend_d     = pend_q;
    hold_pc    = 1'b0;
    hold_ifid  = 1'b0;
    flush_ifid = 1'b0;
    hold_idex  = 1'b0;
    flush_idex = 1'b0;
    hold_exmem = 1'b0;
    hold_memwb = 1'b0;

    if (dstall) begin
      state_d    = S_DWAIT;
      pend_d     = pend_q || i_redirect_EX;
      hold_pc    = 1'b1;
      hold_ifid  = 1'b1;
      hold_idex  = 1'b1;
      hold_exmem = 1'b1;
      hold_memwb = 1'b1;
    end else begin
      state_d = istall ? S_IWAIT : S_RUN;
      pend_d  = pend_q && istall;
      if (redir) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        lu_d       = '0;
        // A fetch still in flight belongs to the old path.
        pend_d     = istall;
      end else if (lu_act) begin
        hold_pc    = 1'b1;
        hold_ifid  = 1'b1;
        flush_idex = 1'b1;
        if (lu_q != '0) begin
          lu_d = lu_q - 1'b1;
        end else if (hit_ex) begin
          lu_d = LU_W'(LU_DEPTH_EX - 1);
        end else begin
          lu_d = LU_W'(LU_DEPTH_MEM - 1);
        end
      end else if (istall) begin
        hold_pc    = 1'b1;
        flush_ifid = 1'b1;
      end else if (in_iw && pend_q) begin
        flush_ifid = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_RUN;
      lu_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      pend_q  <= pend_d;
    end
  end

  assign hold_pc_g    = hold_pc && !i_rst;
  assign waiting      = (state_q != S_RUN) && !i_rst;
  assign o_hold_PC    = hold_pc_g;
  assign o_hold_IFID  = hold_ifid && !flush_ifid && !i_rst;
  assign o_flush_IFID = flush_ifid && !i_rst;
  assign o_hold_IDEX  = hold_idex && !flush_idex && !i_rst;
  assign o_flush_IDEX = flush_idex && !i_rst;
  assign o_hold_EXMEM = hold_exmem && !i_rst;
  assign o_hold_MEMWB = hold_memwb && !i_rst;

  hazard_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk_i          (i_clk),
    .rst_i          (i_rst),
    .waiting_i      (waiting),
    .hold_pc_i      (hold_pc_g),
    .stall_cycles_o (o_stall_cycles),
    .timeout_o      (o_timeout)
  );

endmodule
